// File: rtl/morse_encoder.sv
// Morse transmit encoder: 6-bit character codes in, ITU-timed key line out.
// Optional 4-entry input FIFO enabled with MORSE_ENC_QUEUE_EN.
module morse_encoder #(
   parameter int DASH_UNITS     = 3,
   parameter int ELEM_GAP_UNITS = 1,
   parameter int CHAR_GAP_UNITS = 3,
   parameter int WORD_GAP_UNITS = 7,
   parameter int CNT_W          = 4
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       tick,
   input  logic       char_valid,
   input  logic [5:0] char_code,
   output logic       char_ready,
   output logic       key_out,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE, MARK, ESPACE, CGAP, WGAP
   } state_t;

   localparam logic [CNT_W-1:0] DOT_L  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DASH_L = CNT_W'(DASH_UNITS);
   localparam logic [CNT_W-1:0] EGAP_L = CNT_W'(ELEM_GAP_UNITS);
   localparam logic [CNT_W-1:0] CGAP_L = CNT_W'(CHAR_GAP_UNITS);
   localparam logic [CNT_W-1:0] WGAP_L = CNT_W'(WORD_GAP_UNITS);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       sh;
   logic [2:0]       rem;
   logic             take;
   logic [5:0]       code;
   logic [2:0]       rom_len;
   logic [4:0]       rom_pat;
   logic [CNT_W-1:0] lim;
   logic             unit_end;

`ifdef MORSE_ENC_QUEUE_EN
   logic [5:0] fifo [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] fill;
   logic       push;
   logic       pop;

   assign pop  = (state == IDLE) && (fill != 3'd0);
   // A pop frees a slot this cycle, so a full FIFO can still take a push.
   assign char_ready = (fill != 3'd4) || pop;
   assign push = char_valid && char_ready;
   assign take = pop;
   assign code = fifo[rd_ptr];

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         for (int i = 0; i < 4; i++) fifo[i] <= '0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= char_code;
            wr_ptr       <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         fill <= fill + 3'(push) - 3'(pop);
      end
   end
`else
   assign char_ready = (state == IDLE);
   assign take = char_valid && char_ready;
   assign code = char_code;
`endif

   assign busy = (state != IDLE);

   // Pattern bits are 1=dash, 0=dot; first element sent is pat[len-1].
   always_comb begin
      rom_len = 3'd0;
      rom_pat = 5'b00000;
      case (code)
         6'd0:  begin rom_len = 3'd2; rom_pat = 5'b00001; end
         6'd1:  begin rom_len = 3'd4; rom_pat = 5'b01000; end
         6'd2:  begin rom_len = 3'd4; rom_pat = 5'b01010; end
         6'd3:  begin rom_len = 3'd3; rom_pat = 5'b00100; end
         6'd4:  begin rom_len = 3'd1; rom_pat = 5'b00000; end
         6'd5:  begin rom_len = 3'd4; rom_pat = 5'b00010; end
         6'd6:  begin rom_len = 3'd3; rom_pat = 5'b00110; end
         6'd7:  begin rom_len = 3'd4; rom_pat = 5'b00000; end
         6'd8:  begin rom_len = 3'd2; rom_pat = 5'b00000; end
         6'd9:  begin rom_len = 3'd4; rom_pat = 5'b00111; end
         6'd10: begin rom_len = 3'd3; rom_pat = 5'b00101; end
         6'd11: begin rom_len = 3'd4; rom_pat = 5'b00100; end
         6'd12: begin rom_len = 3'd2; rom_pat = 5'b00011; end
         6'd13: begin rom_len = 3'd2; rom_pat = 5'b00010; end
         6'd14: begin rom_len = 3'd3; rom_pat = 5'b00111; end
         6'd15: begin rom_len = 3'd4; rom_pat = 5'b00110; end
         6'd16: begin rom_len = 3'd4; rom_pat = 5'b01101; end
         6'd17: begin rom_len = 3'd3; rom_pat = 5'b00010; end
         6'd18: begin rom_len = 3'd3; rom_pat = 5'b00000; end
         6'd19: begin rom_len = 3'd1; rom_pat = 5'b00001; end
         6'd20: begin rom_len = 3'd3; rom_pat = 5'b00001; end
         6'd21: begin rom_len = 3'd4; rom_pat = 5'b00001; end
         6'd22: begin rom_len = 3'd3; rom_pat = 5'b00011; end
         6'd23: begin rom_len = 3'd4; rom_pat = 5'b01001; end
         6'd24: begin rom_len = 3'd4; rom_pat = 5'b01011; end
         6'd25: begin rom_len = 3'd4; rom_pat = 5'b01100; end
         6'd26: begin rom_len = 3'd5; rom_pat = 5'b11111; end
         6'd27: begin rom_len = 3'd5; rom_pat = 5'b01111; end
         6'd28: begin rom_len = 3'd5; rom_pat = 5'b00111; end
         6'd29: begin rom_len = 3'd5; rom_pat = 5'b00011; end
         6'd30: begin rom_len = 3'd5; rom_pat = 5'b00001; end
         6'd31: begin rom_len = 3'd5; rom_pat = 5'b00000; end
         6'd32: begin rom_len = 3'd5; rom_pat = 5'b10000; end
         6'd33: begin rom_len = 3'd5; rom_pat = 5'b11000; end
         6'd34: begin rom_len = 3'd5; rom_pat = 5'b11100; end
         6'd35: begin rom_len = 3'd5; rom_pat = 5'b11110; end
         default: begin rom_len = 3'd0; rom_pat = 5'b00000; end
      endcase
   end

   always_comb begin
      lim = DOT_L;
      case (state)
         MARK:    lim = sh[4] ? DASH_L : DOT_L;
         ESPACE:  lim = EGAP_L;
         CGAP:    lim = CGAP_L;
         WGAP:    lim = WGAP_L;
         default: lim = DOT_L;
      endcase
   end

   assign unit_end = tick && (cnt == lim - DOT_L);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         sh      <= '0;
         rem     <= '0;
         key_out <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (take) begin
                  if (code < 6'd36) begin
                     state   <= MARK;
                     key_out <= 1'b1;
                     // Left-align so the element in flight is always sh[4].
                     sh      <= 5'(rom_pat << (3'd5 - rom_len));
                     rem     <= rom_len - 3'd1;
                  end else if (code == 6'd36) begin
                     state <= WGAP;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            MARK: begin
               if (unit_end) begin
                  cnt     <= '0;
                  key_out <= 1'b0;
                  state   <= (rem != 3'd0) ? ESPACE : CGAP;
               end else if (tick) begin
                  cnt <= cnt + DOT_L;
               end
            end
            ESPACE: begin
               if (unit_end) begin
                  cnt     <= '0;
                  key_out <= 1'b1;
                  sh      <= {sh[3:0], 1'b0};
                  rem     <= rem - 3'd1;
                  state   <= MARK;
               end else if (tick) begin
                  cnt <= cnt + DOT_L;
               end
            end
            CGAP, WGAP: begin
               if (unit_end) begin
                  cnt   <= '0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else if (tick) begin
                  cnt <= cnt + DOT_L;
               end
            end
            default: begin
               state   <= IDLE;
               key_out <= 1'b0;
               cnt     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder (default build, no input FIFO).
// Key waveforms are rebuilt from dot/dash strings with ITU unit timing.
module tb_morse_encoder;

   logic       clock;
   logic       rst;
   logic       tick;
   logic       char_valid;
   logic [5:0] char_code;
   logic       char_ready;
   logic       key_out;
   logic       busy;
   logic       done;
   logic       err;

   int checks;
   int failures;
   int tick_period;
   int tick_cnt;

   logic [63:0] keys;
   int done_at;
   int done_cnt;
   int err_cnt;
   int busy_cnt;
   int on_cnt;
   int runs;
   int ready_busy;
   logic ready_at_done;

   string tab [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
      ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
      "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-", ".....",
      "-....", "--...", "---..", "----."
   };

   morse_encoder dut (
      .clock      (clock),
      .rst        (rst),
      .tick       (tick),
      .char_valid (char_valid),
      .char_code  (char_code),
      .char_ready (char_ready),
      .key_out    (key_out),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
      tick_cnt++;
      tick = (tick_cnt % tick_period) == 0;
   endtask

   task automatic send(input logic [5:0] c);
      tick_cnt   = 0;
      tick       = 1'b1;
      char_valid = 1'b1;
      char_code  = c;
      cyc();
      char_valid = 1'b0;
      char_code  = 6'h3f;
   endtask

   // Samples cycles 1..n after an accept.
   task automatic run(input int n);
      logic prev;
      prev          = 1'b0;
      keys          = '0;
      done_at       = -1;
      done_cnt      = 0;
      err_cnt       = 0;
      busy_cnt      = 0;
      on_cnt        = 0;
      runs          = 0;
      ready_busy    = 0;
      ready_at_done = 1'b0;
      for (int i = 1; i <= n; i++) begin
         keys = {keys[62:0], key_out};
         if (key_out) on_cnt++;
         if (key_out && !prev) runs++;
         prev = key_out;
         if (busy) busy_cnt++;
         if (busy && char_ready) ready_busy++;
         if (err) err_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at       = i;
               ready_at_done = char_ready;
            end
         end
         cyc();
      end
   endtask

   task automatic char_test(input int idx);
      string       s;
      logic [63:0] exp;
      int          len;
      s   = tab[idx];
      exp = '0;
      len = 0;
      for (int i = 0; i < s.len(); i++) begin
         if (i != 0) begin
            exp = {exp[62:0], 1'b0};
            len++;
         end
         for (int k = 0; k < ((s[i] == "-") ? 3 : 1); k++) begin
            exp = {exp[62:0], 1'b1};
            len++;
         end
      end
      exp = exp << 5;
      send(6'(idx));
      run(len + 5);
      check($sformatf("wave_%0d", idx), keys, exp);
      check($sformatf("done_%0d", idx), 64'(done_at), 64'(len + 4));
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      tick_period = 1;
      tick_cnt    = 0;
      tick        = 1'b0;
      char_valid  = 1'b0;
      char_code   = '0;
      rst         = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_key", 64'(key_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_ready", 64'(char_ready), 64'd1);
      rst = 1'b0;
      cyc();

      send(6'd4);
      run(6);
      check("e_wave", keys, 64'b100000);
      check("e_done_at", 64'(done_at), 64'd5);
      check("e_ready_done", 64'(ready_at_done), 64'd1);
      check("e_ready_busy", 64'(ready_busy), 64'd0);

      send(6'd0);
      run(10);
      check("a_wave", keys, 64'b1011100000);
      check("a_done_at", 64'(done_at), 64'd9);

      send(6'd36);
      run(10);
      check("sp_keys", keys, 64'd0);
      check("sp_busy", 64'(busy_cnt), 64'd7);
      check("sp_done_at", 64'(done_at), 64'd8);

      send(6'd45);
      run(6);
      check("inv_err", 64'(err_cnt), 64'd1);
      check("inv_busy", 64'(busy_cnt), 64'd0);
      check("inv_done", 64'(done_cnt), 64'd0);
      check("inv_keys", keys, 64'd0);

      tick_period = 4;
      send(6'd26);
      run(92);
      check("d0_on", 64'(on_cnt), 64'd60);
      check("d0_runs", 64'(runs), 64'd5);
      check("d0_done_cnt", 64'(done_cnt), 64'd1);
      check("d0_done_at", 64'(done_at), 64'd89);
      tick_period = 1;
      tick_cnt    = 0;
      tick        = 1'b1;

      send(6'd18);
      run(2);
      check("s_mid_key", 64'(key_out), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_key", 64'(key_out), 64'd0);
      check("abort_ready", 64'(char_ready), 64'd1);
      cyc();
      rst = 1'b0;
      cyc();
      send(6'd18);
      run(10);
      check("s_wave", keys, 64'b1010100000);
      check("s_done_at", 64'(done_at), 64'd9);

      for (int i = 0; i < 36; i++) char_test(i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
